// File: rtl/frame_buffer_manager_if.sv
// Frame-buffer manager bus: writer/display events in, buffer bases and status out.
// Optional FB_STATS_EN adds the dropped/repeated frame counters.
interface frame_buffer_manager_if;
  logic        wr_done;
  logic        rd_vsync;
  logic [31:0] wr_base;
  logic [31:0] rd_base;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic        buf_valid;
  logic        swap_pulse;
  logic        wr_hold;
`ifdef FB_STATS_EN
  logic [15:0] frames_dropped;
  logic [15:0] frames_repeated;
`endif

  modport master (
    output wr_done, rd_vsync,
    input  wr_base, rd_base, wr_idx, rd_idx, buf_valid, swap_pulse, wr_hold
`ifdef FB_STATS_EN
    , input frames_dropped, frames_repeated
`endif
  );

  modport slave (
    input  wr_done, rd_vsync,
    output wr_base, rd_base, wr_idx, rd_idx, buf_valid, swap_pulse, wr_hold
`ifdef FB_STATS_EN
    , output frames_dropped, frames_repeated
`endif
  );
endinterface

// File: rtl/frame_buffer_manager.sv
// Frame-buffer ownership between the camera writer and the HDMI reader.
// Triple (NUM_BUF=3) or double (NUM_BUF=2, writer hold-off) buffering.
// Optional macro FB_STATS_EN adds saturating dropped/repeated frame counters.
//
// state    | meaning
// S_INIT   | no frame written since reset; display repeats the initial buffer
// S_PEND   | a complete frame waits for the next vsync
// S_STEADY | display owns the newest frame; nothing pending
module frame_buffer_manager #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0009_6000,
  parameter int          NUM_BUF     = 3
) (
  input  logic                  clk_100Mhz,
  input  logic                  rst,
  frame_buffer_manager_if.slave fb
);

  if (NUM_BUF != 2 && NUM_BUF != 3) begin : g_bad_num_buf
    $error("frame_buffer_manager: NUM_BUF must be 2 or 3");
  end

  typedef enum logic [1:0] {S_INIT, S_PEND, S_STEADY} state_t;

  localparam logic [1:0] R_RESET = 2'(NUM_BUF - 1);

  state_t      state_q, st_mid, st_n;
  logic        wr_done_d, rd_vsync_d;
  logic        wr_ev, vs_ev;
  logic [1:0]  w_q, p_q, r_q;
  logic [1:0]  w_n, p_n, r_n, p_mid;
  logic [31:0] wr_base_q, rd_base_q;
  logic        hold_q, hold_n, valid_q, valid_n, swap_q, swap_n;
  logic        drop, rep;

  function automatic logic [31:0] addr_of(input logic [1:0] idx);
    return BASE_ADDR + ({30'd0, idx} * FRAME_BYTES);
  endfunction

  assign wr_ev = fb.wr_done & ~wr_done_d;
  assign vs_ev = fb.rd_vsync & ~rd_vsync_d;

  // State and registered outputs; async reset returns everything to power-up values.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      wr_done_d  <= 1'b0;
      rd_vsync_d <= 1'b0;
      w_q        <= 2'd0;
      p_q        <= 2'd1;
      r_q        <= R_RESET;
      wr_base_q  <= BASE_ADDR;
      rd_base_q  <= addr_of(R_RESET);
      hold_q     <= 1'b0;
      valid_q    <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= st_n;
      wr_done_d  <= fb.wr_done;
      rd_vsync_d <= fb.rd_vsync;
      w_q        <= w_n;
      p_q        <= p_n;
      r_q        <= r_n;
      wr_base_q  <= addr_of(w_n);
      rd_base_q  <= addr_of(r_n);
      hold_q     <= hold_n;
      valid_q    <= valid_n;
      swap_q     <= swap_n;
    end
  end

  // Next state: the write event is applied first, then vsync sees the result.
  always_comb begin
    st_mid = state_q;
    if (wr_ev) st_mid = S_PEND;
    st_n = st_mid;
    if (vs_ev && st_mid == S_PEND) st_n = S_STEADY;
  end

  // Index rotation and flag updates, same write-then-vsync ordering as the state.
  always_comb begin
    w_n    = w_q;
    p_mid  = p_q;
    p_n    = p_q;
    r_n    = r_q;
    hold_n = hold_q;
    valid_n = valid_q;
    swap_n = 1'b0;
    drop   = 1'b0;
    rep    = 1'b0;
    if (NUM_BUF == 3) begin
      if (wr_ev) begin
        w_n   = p_q;
        p_mid = w_q;
        drop  = (state_q == S_PEND);
      end
      p_n = p_mid;
      if (vs_ev) begin
        if (st_mid == S_PEND) begin
          r_n     = p_mid;
          p_n     = r_q;
          swap_n  = 1'b1;
          valid_n = 1'b1;
        end else begin
          rep = 1'b1;
        end
      end
    end else begin
      if (wr_ev) begin
        if (state_q == S_PEND) drop = 1'b1;
        else hold_n = 1'b1;
      end
      if (vs_ev) begin
        if (st_mid == S_PEND) begin
          w_n     = r_q;
          r_n     = w_q;
          hold_n  = 1'b0;
          swap_n  = 1'b1;
          valid_n = 1'b1;
        end else begin
          rep = 1'b1;
        end
      end
    end
  end

  assign fb.wr_base    = wr_base_q;
  assign fb.rd_base    = rd_base_q;
  assign fb.wr_idx     = w_q;
  assign fb.rd_idx     = r_q;
  assign fb.buf_valid  = valid_q;
  assign fb.swap_pulse = swap_q;
  assign fb.wr_hold    = hold_q;

`ifdef FB_STATS_EN
  logic [15:0] dropped_q, repeated_q;

  // Saturating event counters for dropped and repeated frames.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      dropped_q  <= 16'd0;
      repeated_q <= 16'd0;
    end else begin
      if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      if (rep && repeated_q != 16'hFFFF) repeated_q <= repeated_q + 16'd1;
    end
  end

  assign fb.frames_dropped  = dropped_q;
  assign fb.frames_repeated = repeated_q;
`else
  logic unused_stats;
  assign unused_stats = drop ^ rep;
`endif

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Scoreboard bench for frame_buffer_manager: triple- and double-buffer instances.
// Swap expectations are queued by the stimulus and checked by a monitor on swap_pulse.
module tb_frame_buffer_manager;
  logic clk_100Mhz;
  logic rst;

  frame_buffer_manager_if fb3();
  frame_buffer_manager_if fb2();

  frame_buffer_manager #(.NUM_BUF(3)) u_dut3 (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .fb(fb3.slave));
  frame_buffer_manager #(.NUM_BUF(2)) u_dut2 (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .fb(fb2.slave));

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] wr;
    logic        hold;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];
  int   passed = 0;
  int   total  = 0;
  int   sp3_cnt = 0;
  int   sp2_cnt = 0;
  int   distinct_bad = 0;
  int   sp_before;

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic do_reset();
    fb3.wr_done = 1'b0; fb3.rd_vsync = 1'b0;
    fb2.wr_done = 1'b0; fb2.rd_vsync = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Monitor: pops an expectation for every swap pulse and tracks index distinctness.
  always @(negedge clk_100Mhz) begin
    if (!rst) begin
      if (fb3.wr_idx == fb3.rd_idx) distinct_bad++;
      if (fb2.wr_idx == fb2.rd_idx) distinct_bad++;
      if (fb3.swap_pulse) begin
        exp_t e;
        sp3_cnt++;
        if (q3.size() == 0) begin
          total++;
          $display("FAIL swap3_unexpected: got swap_pulse=1 expected no swap");
        end else begin
          e = q3.pop_front();
          chk("swap3_rd_base", fb3.rd_base, e.rd);
          chk("swap3_wr_base", fb3.wr_base, e.wr);
          chk("swap3_buf_valid", {31'd0, fb3.buf_valid}, 32'd1);
        end
      end
      if (fb2.swap_pulse) begin
        exp_t e;
        sp2_cnt++;
        if (q2.size() == 0) begin
          total++;
          $display("FAIL swap2_unexpected: got swap_pulse=1 expected no swap");
        end else begin
          e = q2.pop_front();
          chk("swap2_rd_base", fb2.rd_base, e.rd);
          chk("swap2_wr_base", fb2.wr_base, e.wr);
          chk("swap2_wr_hold", {31'd0, fb2.wr_hold}, {31'd0, e.hold});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    do_reset();

    // Reset values
    chk("rst3_wr_base", fb3.wr_base, 32'h1000_0000);
    chk("rst3_rd_base", fb3.rd_base, 32'h1012_C000);
    chk("rst3_buf_valid", {31'd0, fb3.buf_valid}, 32'd0);
    chk("rst3_swap_pulse", {31'd0, fb3.swap_pulse}, 32'd0);
    chk("rst3_idx", {28'd0, fb3.wr_idx, fb3.rd_idx}, 32'h2);
    chk("rst2_rd_base", fb2.rd_base, 32'h1009_6000);
    chk("rst2_wr_hold", {31'd0, fb2.wr_hold}, 32'd0);

    // Single frame, long vsync: exactly one swap
    sp_before = sp3_cnt;
    fb3.wr_done = 1'b1; tick(); fb3.wr_done = 1'b0;
    q3.push_back('{rd: 32'h1000_0000, wr: 32'h1009_6000, hold: 1'b0});
    fb3.rd_vsync = 1'b1; repeat (4) tick(); fb3.rd_vsync = 1'b0; tick();
    chk("t2_swap_count", 32'(sp3_cnt - sp_before), 32'd1);
    chk("t2_rd_base", fb3.rd_base, 32'h1000_0000);
    chk("t2_wr_base", fb3.wr_base, 32'h1009_6000);
    chk("t2_buf_valid", {31'd0, fb3.buf_valid}, 32'd1);

    // Vsync with no frame: repeat, no swap
    do_reset();
    sp_before = sp3_cnt;
    fb3.rd_vsync = 1'b1; tick(); tick(); fb3.rd_vsync = 1'b0; tick();
    chk("t3_swap_count", 32'(sp3_cnt - sp_before), 32'd0);
    chk("t3_rd_base", fb3.rd_base, 32'h1012_C000);
    chk("t3_wr_base", fb3.wr_base, 32'h1000_0000);
    chk("t3_buf_valid", {31'd0, fb3.buf_valid}, 32'd0);
`ifdef FB_STATS_EN
    chk("t3_frames_repeated", {16'd0, fb3.frames_repeated}, 32'd1);
`endif

    // Two frames before vsync: first one dropped
    do_reset();
    fb3.wr_done = 1'b1; tick(); fb3.wr_done = 1'b0; tick();
    fb3.wr_done = 1'b1; tick(); fb3.wr_done = 1'b0; tick();
    q3.push_back('{rd: 32'h1009_6000, wr: 32'h1000_0000, hold: 1'b0});
    fb3.rd_vsync = 1'b1; tick(); fb3.rd_vsync = 1'b0; tick();
    chk("t4_rd_base", fb3.rd_base, 32'h1009_6000);
    chk("t4_wr_base", fb3.wr_base, 32'h1000_0000);
`ifdef FB_STATS_EN
    chk("t4_frames_dropped", {16'd0, fb3.frames_dropped}, 32'd1);
`endif

    // Simultaneous write-done and vsync
    do_reset();
    q3.push_back('{rd: 32'h1000_0000, wr: 32'h1009_6000, hold: 1'b0});
    fb3.wr_done = 1'b1; fb3.rd_vsync = 1'b1; tick();
    chk("t5_swap_pulse", {31'd0, fb3.swap_pulse}, 32'd1);
    fb3.wr_done = 1'b0; fb3.rd_vsync = 1'b0; tick();
    chk("t5_swap_pulse_clear", {31'd0, fb3.swap_pulse}, 32'd0);
    chk("t5_rd_base", fb3.rd_base, 32'h1000_0000);

    // Double buffering: hold-off, swap, then a frame written under hold is dropped
    do_reset();
    fb2.wr_done = 1'b1; tick(); fb2.wr_done = 1'b0; tick();
    chk("t6_wr_hold_set", {31'd0, fb2.wr_hold}, 32'd1);
    chk("t6_rd_base_held", fb2.rd_base, 32'h1009_6000);
    q2.push_back('{rd: 32'h1000_0000, wr: 32'h1009_6000, hold: 1'b0});
    fb2.rd_vsync = 1'b1; tick(); fb2.rd_vsync = 1'b0; tick();
    chk("t6_wr_hold_clear", {31'd0, fb2.wr_hold}, 32'd0);
    chk("t6_buf_valid", {31'd0, fb2.buf_valid}, 32'd1);
    fb2.wr_done = 1'b1; tick(); fb2.wr_done = 1'b0; tick();
    fb2.wr_done = 1'b1; tick(); fb2.wr_done = 1'b0; tick();
    q2.push_back('{rd: 32'h1009_6000, wr: 32'h1000_0000, hold: 1'b0});
    fb2.rd_vsync = 1'b1; tick(); fb2.rd_vsync = 1'b0; tick();
    chk("t6_rd_base_second", fb2.rd_base, 32'h1009_6000);
`ifdef FB_STATS_EN
    chk("t6_frames_dropped", {16'd0, fb2.frames_dropped}, 32'd1);
`endif

    // Asynchronous reset mid-stream
    fb2.wr_done = 1'b1; fb3.wr_done = 1'b1; tick();
    fb2.wr_done = 1'b0; fb3.wr_done = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst2_wr_hold", {31'd0, fb2.wr_hold}, 32'd0);
    chk("arst2_wr_base", fb2.wr_base, 32'h1000_0000);
    chk("arst2_rd_base", fb2.rd_base, 32'h1009_6000);
    chk("arst2_buf_valid", {31'd0, fb2.buf_valid}, 32'd0);
    chk("arst3_wr_base", fb3.wr_base, 32'h1000_0000);
    chk("arst3_rd_base", fb3.rd_base, 32'h1012_C000);
    chk("arst3_buf_valid", {31'd0, fb3.buf_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();

    chk("idx_distinct_violations", 32'(distinct_bad), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
